// File: rtl/fec_derand_rx.sv
// Receive chain: hard-decision K=7 rate-1/2 tail-biting Viterbi decoder (G1=171o, G2=133o)
// followed by a 1+x^14+x^15 PRBS de-randomizer; decoded bits leave serially, first bit first.

module fec_derand_rx_chk #(
    parameter int N_BITS = 96,
    parameter int PM_W   = 8
) (
    input logic clk,
    input logic reset_n
);
    // Path metrics are never normalized, so the worst-case block metric must fit in PM_W bits
    always @(posedge clk) begin
        if (reset_n) begin
            assert ((2 * N_BITS) < (2 ** PM_W));
        end
    end
endmodule

module fec_derand_rx #(
    parameter int N_BITS = 96,
    parameter int PM_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:1] seed,
    input  logic        dec_valid_in,
    input  logic [1:0]  dec_data_in,
    output logic        dec_ready_out,
    output logic        rx_data_out,
    output logic        rx_valid_out,
    output logic        block_done
);
    localparam int CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACS    = 3'd1,
        ST_SELECT = 3'd2,
        ST_TRACE  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    function automatic logic [1:0] enc_sym(input logic [5:0] s, input logic u);
        return {u ^ s[5] ^ s[4] ^ s[3] ^ s[0], u ^ s[4] ^ s[3] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // Returns {decision, metric}; decision is the LSB of the surviving predecessor.
    function automatic logic [PM_W:0] acs_node(input logic clr, input logic [PM_W-1:0] pm_a,
                                               input logic [PM_W-1:0] pm_b, input logic [5:0] n,
                                               input logic [1:0] rx);
        logic [PM_W-1:0] ma;
        logic [PM_W-1:0] mb;
        ma = (clr ? {PM_W{1'b0}} : pm_a) + PM_W'(hamming2(enc_sym({n[4:0], 1'b0}, n[5]), rx));
        mb = (clr ? {PM_W{1'b0}} : pm_b) + PM_W'(hamming2(enc_sym({n[4:0], 1'b1}, n[5]), rx));
        if (mb < ma) begin
            return {1'b1, mb};
        end else begin
            return {1'b0, ma};
        end
    endfunction

    // seed[15] is the earliest-written bit and sits next to the feedback input (r[1]).
    function automatic logic [15:1] rev_seed(input logic [15:1] s);
        logic [15:1] r;
        for (int k = 1; k <= 15; k++) begin
            r[k] = s[16 - k];
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [PM_W-1:0]     pm_q [64];
    logic [PM_W-1:0]     pm_d [64];
    logic [63:0]         surv_row_d;
    logic [63:0]         surv_q [N_BITS];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [5:0]          sel_idx_q, sel_idx_d;
    logic [5:0]          best_st_q, best_st_d;
    logic [5:0]          trace_st_q, trace_st_d;
    logic [PM_W-1:0]     best_pm_q, best_pm_d;
    logic [PM_W-1:0]     sel_pm_s;
    logic [N_BITS-1:0]   lifo_q, lifo_d;
    logic [15:1]         prbs_q, prbs_d;
    logic [15:1]         seed_q;
    logic                ready_q, ready_d;
    logic                data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                acc_s, acs_en_s, fb_s, surv_bit_s;

    assign acc_s      = dec_valid_in & ready_q;
    assign fb_s       = prbs_q[14] ^ prbs_q[15];
    assign sel_pm_s   = pm_q[sel_idx_q];
    assign surv_bit_s = surv_q[cnt_q][trace_st_q];

    // Add-compare-select for all 64 states; metrics start from zero at block start (tail-biting)
    always_comb begin
        surv_row_d = 64'd0;
        for (int n = 0; n < 64; n++) begin
            {surv_row_d[n], pm_d[n]} = acs_node(state_q == ST_IDLE, pm_q[2 * (n % 32)],
                                                pm_q[2 * (n % 32) + 1], 6'(n), dec_data_in);
        end
    end

    // Block sequencing: ACS -> minimum-metric scan -> traceback into LIFO -> de-randomized output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_idx_d  = sel_idx_q;
        best_pm_d  = best_pm_q;
        best_st_d  = best_st_q;
        trace_st_d = trace_st_q;
        lifo_d     = lifo_q;
        prbs_d     = prbs_q;
        data_d     = 1'b0;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        acs_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    acs_en_s = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_ACS;
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            ST_ACS: begin
                if (acc_s) begin
                    acs_en_s = 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        cnt_d     = {CNT_W{1'b0}};
                        sel_idx_d = 6'd0;
                        state_d   = ST_SELECT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    acs_en_s = 1'b0;
                end
            end
            ST_SELECT: begin
                // Strict less-than keeps the lowest index among equal metrics
                if ((sel_idx_q == 6'd0) || (sel_pm_s < best_pm_q)) begin
                    best_pm_d = sel_pm_s;
                    best_st_d = sel_idx_q;
                end else begin
                    best_pm_d = best_pm_q;
                end
                sel_idx_d = sel_idx_q + 6'd1;
                if (sel_idx_q == 6'd63) begin
                    trace_st_d = best_st_d;
                    cnt_d      = LAST_STEP;
                    state_d    = ST_TRACE;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_TRACE: begin
                lifo_d     = {lifo_q[N_BITS-2:0], trace_st_q[5]};
                trace_st_d = {trace_st_q[4:0], surv_bit_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    prbs_d  = rev_seed(seed_q);
                    state_d = ST_OUTPUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                valid_d = 1'b1;
                data_d  = lifo_q[0] ^ fb_s;
                lifo_d  = {1'b0, lifo_q[N_BITS-1:1]};
                prbs_d  = {prbs_q[14:1], fb_s};
                if (cnt_q == LAST_STEP) begin
                    done_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_ACS);
    end

    // Survivor memory: one decision row per trellis step, no reset needed
    always_ff @(posedge clk) begin
        if (acs_en_s) begin
            surv_q[cnt_q] <= surv_row_d;
        end
    end

    // Control, metric, LIFO, PRBS and registered output state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < 64; i++) begin
                pm_q[i] <= {PM_W{1'b0}};
            end
            cnt_q      <= {CNT_W{1'b0}};
            sel_idx_q  <= 6'd0;
            best_st_q  <= 6'd0;
            best_pm_q  <= {PM_W{1'b0}};
            trace_st_q <= 6'd0;
            lifo_q     <= {N_BITS{1'b0}};
            prbs_q     <= 15'd0;
            seed_q     <= 15'd0;
            ready_q    <= 1'b0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (acs_en_s) begin
                for (int i = 0; i < 64; i++) begin
                    pm_q[i] <= pm_d[i];
                end
            end
            cnt_q      <= cnt_d;
            sel_idx_q  <= sel_idx_d;
            best_st_q  <= best_st_d;
            best_pm_q  <= best_pm_d;
            trace_st_q <= trace_st_d;
            lifo_q     <= lifo_d;
            prbs_q     <= prbs_d;
            if (load) begin
                seed_q <= seed;
            end
            ready_q    <= ready_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign dec_ready_out = ready_q;
    assign rx_data_out   = data_q;
    assign rx_valid_out  = valid_q;
    assign block_done    = done_q;

    fec_derand_rx_chk #(
        .N_BITS (N_BITS),
        .PM_W   (PM_W)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n)
    );

endmodule
